// File: rtl/bus_arbiter_if.sv
// bus_arbiter_if: requester-side (IF, MEM) and memory-side bus signals of the arbiter
//   master: arbiter view (takes requests and bus_ack/rdata, drives bus_*, ready/rdata, stalls)
//   slave : environment view (pipeline requesters plus external memory)
interface bus_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_sel;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        bus_req;
  logic        bus_we;
  logic [3:0]  bus_sel;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic        bus_err;
  logic        stall_if;
  logic        stall_mem;
  modport master(
    input  if_req, if_addr, mem_req, mem_we, mem_sel, mem_addr, mem_wdata, bus_rdata, bus_ack,
    output if_rdata, if_ready, mem_rdata, mem_ready, bus_req, bus_we, bus_sel, bus_addr, bus_wdata,
           bus_err, stall_if, stall_mem
  );
  modport slave(
    output if_req, if_addr, mem_req, mem_we, mem_sel, mem_addr, mem_wdata, bus_rdata, bus_ack,
    input  if_rdata, if_ready, mem_rdata, mem_ready, bus_req, bus_we, bus_sel, bus_addr, bus_wdata,
           bus_err, stall_if, stall_mem
  );
endinterface

// File: rtl/bus_arbiter.sv
// bus_arbiter: shares one memory bus between instruction fetch and data access
//   clk, rst : clock and synchronous active-high reset
//   io_bus   : IF/MEM requests, ready pulses and read data, bus cycle outputs, bus_ack/rdata,
//              bus_err timeout pulse and the two stall requests
module bus_arbiter #(
  parameter int MAX_MEM_RUN = 4,
  parameter int TIMEOUT     = 64
) (
  input  logic          clk,
  input  logic          rst,
  bus_arbiter_if.master io_bus
);
  typedef enum logic [1:0] {IDLE, IF_BUSY, MEM_BUSY} state_t;
  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_run;
  logic [7:0]  r_tmo;
  logic        r_bus_req;
  logic        r_bus_we;
  logic [3:0]  r_bus_sel;
  logic [31:0] r_bus_addr;
  logic [31:0] r_bus_wdata;
  logic [31:0] r_if_rdata;
  logic [31:0] r_mem_rdata;
  logic        r_if_ready;
  logic        r_mem_ready;
  logic        r_err;
  logic        w_if_elig;
  logic        w_mem_elig;
  logic        w_pick_mem;
  logic        w_end;
  // a requester whose ready pulses this cycle has just been served and is not eligible
  always_comb begin
    w_if_elig  = io_bus.if_req & ~r_if_ready;
    w_mem_elig = io_bus.mem_req & ~r_mem_ready;
    w_pick_mem = w_mem_elig & ~(w_if_elig & (r_run == 4'(MAX_MEM_RUN)));
    w_end      = (r_state != IDLE) & (io_bus.bus_ack | (r_tmo == 8'(TIMEOUT - 1)));
    w_next     = r_state;
    w_next     = (r_state == IDLE) ? (w_pick_mem ? MEM_BUSY : (w_if_elig ? IF_BUSY : IDLE))
                                   : (w_end ? IDLE : r_state);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_run       <= '0;
      r_tmo       <= '0;
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_sel   <= '0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
      r_if_rdata  <= '0;
      r_mem_rdata <= '0;
      r_if_ready  <= 1'b0;
      r_mem_ready <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_if_ready  <= 1'b0;
      r_mem_ready <= 1'b0;
      r_err       <= 1'b0;
      if (r_state == IDLE && w_next != IDLE) begin
        r_bus_req <= 1'b1;
        r_tmo     <= '0;
        if (w_pick_mem) begin
          r_bus_we    <= io_bus.mem_we;
          r_bus_sel   <= io_bus.mem_sel;
          r_bus_addr  <= io_bus.mem_addr;
          r_bus_wdata <= io_bus.mem_wdata;
          // run length only grows while IF is waiting; saturates at the limit
          r_run       <= io_bus.if_req ? ((r_run == 4'(MAX_MEM_RUN)) ? r_run : r_run + 4'd1) : 4'd0;
        end else begin
          r_bus_we    <= 1'b0;
          r_bus_sel   <= 4'hF;
          r_bus_addr  <= io_bus.if_addr;
          r_bus_wdata <= '0;
          r_run       <= '0;
        end
      end else if (w_end) begin
        // ack on the last timeout cycle still counts as a normal completion
        r_bus_req <= 1'b0;
        r_err     <= ~io_bus.bus_ack;
        if (r_state == IF_BUSY) begin
          r_if_ready <= 1'b1;
          r_if_rdata <= io_bus.bus_ack ? io_bus.bus_rdata : 32'd0;
        end else begin
          r_mem_ready <= 1'b1;
          r_mem_rdata <= (io_bus.bus_ack & ~r_bus_we) ? io_bus.bus_rdata : 32'd0;
        end
      end else if (r_state != IDLE) begin
        r_tmo <= r_tmo + 8'd1;
      end
    end
  end
  assign io_bus.bus_req   = r_bus_req;
  assign io_bus.bus_we    = r_bus_we;
  assign io_bus.bus_sel   = r_bus_sel;
  assign io_bus.bus_addr  = r_bus_addr;
  assign io_bus.bus_wdata = r_bus_wdata;
  assign io_bus.bus_err   = r_err;
  assign io_bus.if_rdata  = r_if_rdata;
  assign io_bus.if_ready  = r_if_ready;
  assign io_bus.mem_rdata = r_mem_rdata;
  assign io_bus.mem_ready = r_mem_ready;
  assign io_bus.stall_if  = io_bus.if_req & ~r_if_ready;
  assign io_bus.stall_mem = io_bus.mem_req & ~r_mem_ready;
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: table vectors, directed corner sequences and random traffic against a transaction model
module tb_bus_arbiter;
  localparam int MAXRUN = 4;
  localparam int TMO    = 8;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  bus_arbiter_if bi();
  bus_arbiter #(.MAX_MEM_RUN(MAXRUN), .TIMEOUT(TMO)) dut (.clk(clk), .rst(rst), .io_bus(bi));
  int n_chk = 0;
  int n_fail = 0;
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  // model: one in-flight transaction record plus the predicted visible outputs
  bit          m_busy, m_mem;
  int          m_age, m_run;
  logic        e_req, e_we, e_if_rdy, e_mem_rdy, e_err;
  logic [3:0]  e_sel;
  logic [31:0] e_addr, e_wdata, e_if_rdata, e_mem_rdata;
  task automatic model_step();
    bit ie, me;
    if (rst) begin
      m_busy = 0; m_mem = 0; m_age = 0; m_run = 0;
      e_req = 0; e_we = 0; e_if_rdy = 0; e_mem_rdy = 0; e_err = 0;
      e_sel = 0; e_addr = 0; e_wdata = 0; e_if_rdata = 0; e_mem_rdata = 0;
    end else begin
      ie = bi.if_req && !e_if_rdy;
      me = bi.mem_req && !e_mem_rdy;
      e_if_rdy = 0; e_mem_rdy = 0; e_err = 0;
      if (!m_busy) begin
        if (ie || me) begin
          m_mem = me && !(ie && m_run == MAXRUN);
          m_busy = 1; m_age = 0; e_req = 1;
          if (m_mem) begin
            e_addr = bi.mem_addr; e_we = bi.mem_we; e_sel = bi.mem_sel; e_wdata = bi.mem_wdata;
            m_run = bi.if_req ? ((m_run < MAXRUN) ? m_run + 1 : MAXRUN) : 0;
          end else begin
            e_addr = bi.if_addr; e_we = 0; e_sel = 4'hF; e_wdata = 0; m_run = 0;
          end
        end
      end else if (bi.bus_ack || m_age == TMO - 1) begin
        m_busy = 0; e_req = 0; e_err = !bi.bus_ack;
        if (m_mem) begin
          e_mem_rdy = 1; e_mem_rdata = (bi.bus_ack && !e_we) ? bi.bus_rdata : 32'd0;
        end else begin
          e_if_rdy = 1; e_if_rdata = bi.bus_ack ? bi.bus_rdata : 32'd0;
        end
      end else m_age++;
    end
  endtask
  task automatic compare_all();
    check("bus_req", bi.bus_req, e_req);
    check("if_ready", bi.if_ready, e_if_rdy);
    check("mem_ready", bi.mem_ready, e_mem_rdy);
    check("bus_err", bi.bus_err, e_err);
    check("if_rdata", bi.if_rdata, e_if_rdata);
    check("mem_rdata", bi.mem_rdata, e_mem_rdata);
    check("stall_if", bi.stall_if, bi.if_req & !e_if_rdy);
    check("stall_mem", bi.stall_mem, bi.mem_req & !e_mem_rdy);
    if (e_req) begin
      check("bus_addr", bi.bus_addr, e_addr);
      check("bus_we", bi.bus_we, e_we);
      check("bus_sel", bi.bus_sel, e_sel);
      check("bus_wdata", bi.bus_wdata, e_wdata);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask
  typedef struct {
    bit rst, ir, mr, we, ack;
    bit br, irdy, mrdy, err;
  } vec_t;
  vec_t tbl[9];
  initial begin
    int hi, mem_n, got_if, got_mem;
    tbl[0] = '{1, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[1] = '{0, 1, 0, 0, 0, 1, 0, 0, 0};
    tbl[2] = '{0, 1, 0, 0, 1, 0, 1, 0, 0};
    tbl[3] = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[4] = '{0, 1, 1, 0, 0, 1, 0, 0, 0};
    tbl[5] = '{0, 1, 1, 0, 1, 0, 0, 1, 0};
    tbl[6] = '{0, 1, 0, 0, 0, 1, 0, 0, 0};
    tbl[7] = '{0, 1, 0, 0, 1, 0, 1, 0, 0};
    tbl[8] = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    rst = 1;
    bi.if_req = 0; bi.if_addr = 0; bi.mem_req = 0; bi.mem_we = 0; bi.mem_sel = 0;
    bi.mem_addr = 0; bi.mem_wdata = 0; bi.bus_rdata = 0; bi.bus_ack = 0;
    tick();
    tick();
    check("rst_bus_req", bi.bus_req, 0);
    check("rst_bus_addr", bi.bus_addr, 0);
    check("rst_bus_sel", bi.bus_sel, 0);
    check("rst_if_rdata", bi.if_rdata, 0);
    check("rst_ready", {bi.if_ready, bi.mem_ready, bi.bus_err}, 0);
    // IF-only fetch then a collision; MEM wins first
    bi.if_addr = 32'h100; bi.mem_addr = 32'h200; bi.mem_sel = 4'hF; bi.bus_rdata = 32'h3C010001;
    foreach (tbl[i]) begin
      rst = tbl[i].rst; bi.if_req = tbl[i].ir; bi.mem_req = tbl[i].mr;
      bi.mem_we = tbl[i].we; bi.bus_ack = tbl[i].ack;
      tick();
      check($sformatf("tbl%0d_bus_req", i), bi.bus_req, tbl[i].br);
      check($sformatf("tbl%0d_if_ready", i), bi.if_ready, tbl[i].irdy);
      check($sformatf("tbl%0d_mem_ready", i), bi.mem_ready, tbl[i].mrdy);
      check($sformatf("tbl%0d_bus_err", i), bi.bus_err, tbl[i].err);
      if (i == 1) check("t1_bus_addr", bi.bus_addr, 32'h100);
      if (i == 2) check("t1_if_rdata", bi.if_rdata, 32'h3C010001);
      if (i == 4) check("t2_bus_addr", bi.bus_addr, 32'h200);
    end
    // write held stable until ack, read data returned as zero
    bi.mem_req = 1; bi.mem_we = 1; bi.mem_sel = 4'b0011; bi.mem_wdata = 32'hDEADBEEF; bi.mem_addr = 32'h40;
    tick();
    for (int i = 0; i < 3; i++) begin
      check("wr_bus_addr", bi.bus_addr, 32'h40);
      check("wr_bus_we", bi.bus_we, 1);
      check("wr_bus_sel", bi.bus_sel, 4'b0011);
      check("wr_bus_wdata", bi.bus_wdata, 32'hDEADBEEF);
      tick();
    end
    bi.bus_ack = 1;
    tick();
    check("wr_mem_ready", bi.mem_ready, 1);
    check("wr_mem_rdata", bi.mem_rdata, 0);
    bi.mem_req = 0; bi.mem_we = 0; bi.bus_ack = 0;
    tick();
    // timeout with no ack
    bi.if_req = 1; bi.if_addr = 32'h300;
    tick();
    hi = 0;
    for (int i = 0; i < 20 && bi.bus_req; i++) begin
      hi++;
      tick();
    end
    check("tmo_cycles", hi, TMO);
    check("tmo_err", bi.bus_err, 1);
    check("tmo_if_ready", bi.if_ready, 1);
    check("tmo_if_rdata", bi.if_rdata, 0);
    bi.if_req = 0;
    tick();
    // ack on the final timeout cycle completes normally
    bi.if_req = 1; bi.bus_rdata = 32'h12345678;
    tick();
    for (int i = 0; i < TMO - 1; i++) tick();
    bi.bus_ack = 1;
    tick();
    check("tmo_ack_err", bi.bus_err, 0);
    check("tmo_ack_if_ready", bi.if_ready, 1);
    check("tmo_ack_if_rdata", bi.if_rdata, 32'h12345678);
    bi.bus_ack = 0; bi.if_req = 0;
    tick();
    // reset in the middle of a MEM transaction
    bi.mem_req = 1; bi.mem_addr = 32'h500;
    tick();
    tick();
    rst = 1;
    tick();
    check("rst_mid_bus_req", bi.bus_req, 0);
    check("rst_mid_mem_ready", bi.mem_ready, 0);
    rst = 0; bi.mem_req = 0; bi.bus_ack = 1;
    tick();
    check("rst_after_mem_ready", bi.mem_ready, 0);
    bi.bus_ack = 0; bi.if_req = 1; bi.if_addr = 32'h600;
    tick();
    check("rst_idle_grant", bi.bus_req, 1);
    check("rst_idle_addr", bi.bus_addr, 32'h600);
    bi.bus_ack = 1;
    tick();
    bi.if_req = 0; bi.bus_ack = 0;
    tick();
    // continuous MEM traffic must not starve a waiting IF
    bi.mem_req = 1; bi.if_req = 1; bi.bus_ack = 1;
    mem_n = 0; got_if = 0;
    for (int i = 0; i < 40 && !got_if; i++) begin
      tick();
      if (bi.mem_ready) mem_n++;
      if (bi.if_ready) got_if = 1;
    end
    check("starve_if_served", got_if, 1);
    check("starve_mem_bound", mem_n <= MAXRUN, 1);
    bi.if_req = 0;
    got_mem = 0;
    for (int i = 0; i < 6 && !got_mem; i++) begin
      tick();
      if (bi.mem_ready) got_mem = 1;
    end
    check("starve_mem_resumes", got_mem, 1);
    bi.mem_req = 0; bi.bus_ack = 0;
    tick();
    tick();
    // random traffic: requests held until ready, random ack latency and occasional reset
    for (int c = 0; c < 3000; c++) begin
      if (bi.if_req ? bi.if_ready : ($urandom_range(0, 3) == 0)) begin
        bi.if_req = bi.if_req ? 1'($urandom_range(0, 1)) : 1'b1;
        bi.if_addr = $urandom;
      end
      if (bi.mem_req ? bi.mem_ready : ($urandom_range(0, 3) == 0)) begin
        bi.mem_req = bi.mem_req ? 1'($urandom_range(0, 1)) : 1'b1;
        bi.mem_we = 1'($urandom_range(0, 1));
        bi.mem_sel = 4'($urandom);
        bi.mem_addr = $urandom;
        bi.mem_wdata = $urandom;
      end
      bi.bus_ack = ($urandom_range(0, 2) == 0);
      bi.bus_rdata = $urandom;
      rst = ($urandom_range(0, 499) == 0);
      tick();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
